// File: rtl/corr_window_engine.sv
// Template correlation engine: walks a TWxTH window of the frame against the template ROM
// and returns a sum-of-products score with a done pulse. Define CORR_SAT_EN for a saturating accumulator.
module corr_window_engine #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int TW     = 32,
    parameter int TH     = 32,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19,
    parameter int ACC_W  = 32
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iStart,
    input  logic [12:0]              iX,
    input  logic [12:0]              iY,
    output logic                     oFrameRd,
    output logic [ADDR_W-1:0]        oFrameAddr,
    input  logic [PIX_W-1:0]         iFramePix,
    output logic [$clog2(TW*TH)-1:0] oTmplAddr,
    input  logic [PIX_W-1:0]         iTmplPix,
    output logic                     oBusy,
    output logic                     oDone,
    output logic [31:0]              oCorr
);

    localparam int TA_W   = $clog2(TW*TH);
    localparam int PROD_W = 2*PIX_W;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES - TW + 1);
    localparam logic [15:0] I_LAST = 16'(TW - 1);
    localparam logic [15:0] J_LAST = 16'(TH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;

    state_t              state;
    state_t              stateNext;
    logic [1:0]          drainCnt;
    logic [12:0]         xLat;
    logic [12:0]         yLat;
    logic [ADDR_W-1:0]   rowBase;
    logic [15:0]         iIdx;
    logic [15:0]         jIdx;
    logic [15:0]         col;
    logic [15:0]         row;
    logic                lastIdx;
    logic                inFrame_p0;
    logic                vld_p1;
    logic                frameRd_p1;
    logic                vld_p2;
    logic [PROD_W-1:0]   prod_p2;
    logic [ACC_W-1:0]    acc;

    function automatic logic [ACC_W-1:0] accAdd(input logic [ACC_W-1:0] a,
                                                input logic [PROD_W-1:0] p);
`ifdef CORR_SAT_EN
        logic [ACC_W+PROD_W:0] sum;
        sum = (ACC_W+PROD_W+1)'(a) + (ACC_W+PROD_W+1)'(p);
        // Products are non-negative, so once clamped the sum stays clamped.
        if (|sum[ACC_W+PROD_W:ACC_W])
            return '1;
        return sum[ACC_W-1:0];
`else
        return a + ACC_W'(p);
`endif
    endfunction

    assign lastIdx    = (iIdx == I_LAST) && (jIdx == J_LAST);
    assign inFrame_p0 = (col < 16'(H_RES)) && (row < 16'(V_RES));
    assign rowBase    = ADDR_W'(yLat) * ADDR_W'(H_RES) + ADDR_W'(xLat);

    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        oFrameRd  = 1'b0;
        case (state)
            IDLE:    if (iStart) stateNext = SETUP;
            SETUP:   stateNext = RUN;
            RUN: begin
                oFrameRd = inFrame_p0;
                if (lastIdx) stateNext = DRAIN;
            end
            DRAIN:   if (drainCnt == 2'd2) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST || state != DRAIN)
            drainCnt <= 2'd0;
        else
            drainCnt <= drainCnt + 2'd1;
    end

    always_ff @(posedge iCLK) begin
        if (state == IDLE && iStart) begin
            xLat <= iX;
            yLat <= iY;
        end
    end

    // Issue stage (p0): addresses walk incrementally; the only multiply is the SETUP row base.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            iIdx       <= '0;
            jIdx       <= '0;
            col        <= '0;
            row        <= '0;
            oFrameAddr <= '0;
            oTmplAddr  <= '0;
        end else begin
            case (state)
                SETUP: begin
                    iIdx       <= '0;
                    jIdx       <= '0;
                    col        <= 16'(xLat);
                    row        <= 16'(yLat);
                    oFrameAddr <= rowBase;
                    oTmplAddr  <= '0;
                end
                RUN: begin
                    if (!lastIdx) begin
                        oTmplAddr <= oTmplAddr + TA_W'(1);
                        if (iIdx == I_LAST) begin
                            iIdx       <= '0;
                            jIdx       <= jIdx + 16'd1;
                            col        <= 16'(xLat);
                            row        <= row + 16'd1;
                            oFrameAddr <= oFrameAddr + ROW_STEP;
                        end else begin
                            iIdx       <= iIdx + 16'd1;
                            col        <= col + 16'd1;
                            oFrameAddr <= oFrameAddr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: memory data returns; p2: product registered, zero for clipped slots.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            vld_p1     <= 1'b0;
            frameRd_p1 <= 1'b0;
            vld_p2     <= 1'b0;
        end else begin
            vld_p1     <= (state == RUN);
            frameRd_p1 <= oFrameRd;
            vld_p2     <= vld_p1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (frameRd_p1)
            prod_p2 <= PROD_W'(iFramePix) * PROD_W'(iTmplPix);
        else
            prod_p2 <= '0;
    end

    // Stage p3: accumulate; the final sum is visible in the last DRAIN cycle.
    always_ff @(posedge iCLK) begin
        if (iRST || state == SETUP)
            acc <= '0;
        else if (vld_p2)
            acc <= accAdd(acc, prod_p2);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oBusy <= 1'b0;
            oDone <= 1'b0;
            oCorr <= '0;
        end else begin
            oBusy <= (stateNext != IDLE);
            oDone <= (stateNext == DONE);
            if (stateNext == DONE)
                oCorr <= 32'(acc);
        end
    end

endmodule

// File: tb/tb_corr_window_engine.sv
// Bench for corr_window_engine: three instances (2x2/32b, 4x4/32b, 4x4/16b) against a window-level model.
module tb_corr_window_engine;

    localparam int TWK  [3] = '{2, 4, 4};
    localparam int THK  [3] = '{2, 4, 4};
    localparam int ACCK [3] = '{32, 32, 16};

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iStart = 1'b0;
    logic [12:0] iX = '0;
    logic [12:0] iY = '0;

    logic        rdV   [3];
    logic [18:0] addrV [3];
    logic        busyV [3];
    logic        doneV [3];
    logic [31:0] corrV [3];
    logic [7:0]  fpix  [3];
    logic [7:0]  tpix  [3];
    int          tmplV [3];
    logic [1:0]  tmplA;
    logic [3:0]  tmplB;
    logic [3:0]  tmplC;

    assign tmplV[0] = {30'd0, tmplA};
    assign tmplV[1] = {28'd0, tmplB};
    assign tmplV[2] = {28'd0, tmplC};

    corr_window_engine #(.TW(2), .TH(2), .ACC_W(32)) dutA (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iX(iX), .iY(iY),
        .oFrameRd(rdV[0]), .oFrameAddr(addrV[0]), .iFramePix(fpix[0]),
        .oTmplAddr(tmplA), .iTmplPix(tpix[0]),
        .oBusy(busyV[0]), .oDone(doneV[0]), .oCorr(corrV[0]));

    corr_window_engine #(.TW(4), .TH(4), .ACC_W(32)) dutB (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iX(iX), .iY(iY),
        .oFrameRd(rdV[1]), .oFrameAddr(addrV[1]), .iFramePix(fpix[1]),
        .oTmplAddr(tmplB), .iTmplPix(tpix[1]),
        .oBusy(busyV[1]), .oDone(doneV[1]), .oCorr(corrV[1]));

    corr_window_engine #(.TW(4), .TH(4), .ACC_W(16)) dutC (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iX(iX), .iY(iY),
        .oFrameRd(rdV[2]), .oFrameAddr(addrV[2]), .iFramePix(fpix[2]),
        .oTmplAddr(tmplC), .iTmplPix(tpix[2]),
        .oBusy(busyV[2]), .oDone(doneV[2]), .oCorr(corrV[2]));

    always #10 iCLK = ~iCLK;

    int dmode = 0;
    int nCmp = 0;
    int nFail = 0;
    int cyc = 0;

    function automatic logic [7:0] frameVal(input int a);
        if (dmode == 0) return 8'd1;
        if (dmode == 1) return 8'd255;
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] tmplVal(input int n);
        if (dmode == 0) return 8'd1;
        if (dmode == 1) return 8'd255;
        return 8'(n * 13 + 5);
    endfunction

    // Whole-window score straight from the definition: clipped pixels contribute nothing.
    function automatic longint score(input int k, input int x, input int y);
        longint s = 0;
        longint lim;
        for (int j = 0; j < THK[k]; j++)
            for (int i = 0; i < TWK[k]; i++)
                if (x + i < 640 && y + j < 480)
                    s += longint'(frameVal((y + j) * 640 + x + i)) * longint'(tmplVal(j * TWK[k] + i));
        lim = longint'(1) << ACCK[k];
`ifdef CORR_SAT_EN
        if (s > lim - 1) s = lim - 1;
`else
        s = s % lim;
`endif
        return s;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc - 1);
        end
    endtask

    // Memories with fixed one-cycle latency; unread frame slots return junk.
    always @(posedge iCLK) begin
        for (int k = 0; k < 3; k++) begin
            fpix[k] <= rdV[k] ? frameVal(int'(addrV[k])) : 8'hEE;
            tpix[k] <= tmplVal(tmplV[k]);
        end
    end

    bit     act     [3] = '{0, 0, 0};
    int     sN      [3] = '{0, 0, 0};
    int     sx      [3] = '{0, 0, 0};
    int     sy      [3] = '{0, 0, 0};
    int     nextOk  [3] = '{0, 0, 0};
    longint expCorr [3] = '{0, 0, 0};
    longint held    [3] = '{0, 0, 0};

    always @(posedge iCLK) begin
        for (int k = 0; k < 3; k++) begin
            if (iRST) begin
                act[k]    <= 1'b0;
                held[k]   <= 0;
                nextOk[k] <= cyc + 1;
            end else begin
                if (act[k] && cyc == sN[k] + TWK[k] * THK[k] + 4)
                    held[k] <= expCorr[k];
                if (iStart && cyc >= nextOk[k]) begin
                    act[k]     <= 1'b1;
                    sN[k]      <= cyc;
                    sx[k]      <= int'(iX);
                    sy[k]      <= int'(iY);
                    expCorr[k] <= score(k, int'(iX), int'(iY));
                    nextOk[k]  <= cyc + TWK[k] * THK[k] + 6;
                end
            end
        end
        cyc <= cyc + 1;
    end

    int          doneEdge [3];
    int          doneCnt  [3];
    int          readCnt  [3];
    int          accCnt   [3];
    int          accE     [3][8];
    longint      doneCorr [3][8];
    logic [18:0] rdLog    [3][16];
    logic        prevBusy [3] = '{0, 0, 0};

    always @(negedge iCLK) begin
        if (cyc > 0) begin
            for (int k = 0; k < 3; k++) begin
                int e, tt, n, px, py;
                bit win, run, expRd;
                e     = cyc - 1;
                tt    = TWK[k] * THK[k];
                win   = act[k] && e >= sN[k] && e <= sN[k] + tt + 4;
                run   = act[k] && e >= sN[k] + 1 && e <= sN[k] + tt;
                n     = e - sN[k] - 1;
                px    = sx[k] + n % TWK[k];
                py    = sy[k] + n / TWK[k];
                expRd = run && px < 640 && py < 480;
                chk($sformatf("busy%0d", k), longint'(busyV[k]), longint'(win));
                chk($sformatf("done%0d", k), longint'(doneV[k]), longint'(act[k] && e == sN[k] + tt + 4));
                chk($sformatf("corr%0d", k), longint'(corrV[k]), held[k]);
                chk($sformatf("frameRd%0d", k), longint'(rdV[k]), longint'(expRd));
                if (expRd)
                    chk($sformatf("frameAddr%0d", k), longint'(addrV[k]), longint'(py * 640 + px));
                if (run)
                    chk($sformatf("tmplAddr%0d", k), longint'(tmplV[k]), longint'(n));
                if (doneV[k]) begin
                    doneEdge[k] = e;
                    if (doneCnt[k] < 8) doneCorr[k][doneCnt[k]] = longint'(corrV[k]);
                    doneCnt[k]++;
                end
                if (busyV[k] && !prevBusy[k]) begin
                    if (accCnt[k] < 8) accE[k][accCnt[k]] = e;
                    accCnt[k]++;
                end
                prevBusy[k] = busyV[k];
                if (rdV[k]) begin
                    if (readCnt[k] < 16) rdLog[k][readCnt[k]] = addrV[k];
                    readCnt[k]++;
                end
            end
        end
    end

    task automatic clearLogs();
        for (int k = 0; k < 3; k++) begin
            doneEdge[k] = -1;
            doneCnt[k]  = 0;
            readCnt[k]  = 0;
            accCnt[k]   = 0;
        end
    endtask

    task automatic doStart(input int x, input int y, output int e);
        @(negedge iCLK);
        iStart = 1'b1;
        iX     = 13'(x);
        iY     = 13'(y);
        @(negedge iCLK);
        iStart = 1'b0;
        e      = cyc - 1;
    endtask

    int n0;

    initial begin
        clearLogs();
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        chk("reset_busy", longint'(busyV[0]), 0);
        chk("reset_corr", longint'(corrV[1]), 0);

        // Flat frame and template.
        dmode = 0;
        clearLogs();
        doStart(0, 0, n0);
        repeat (30) @(negedge iCLK);
        chk("flat_corrA", longint'(corrV[0]), 4);
        chk("flat_doneA_ofs", longint'(doneEdge[0] - n0), 8);
        chk("flat_doneA_cnt", longint'(doneCnt[0]), 1);
        chk("flat_corrB", longint'(corrV[1]), 16);
        chk("flat_doneB_ofs", longint'(doneEdge[1] - n0), 20);

        // Reset for three cycles while the 2x2 engine is in RUN.
        clearLogs();
        doStart(0, 0, n0);
        @(negedge iCLK);
        iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        repeat (30) @(negedge iCLK);
        chk("rst_doneA_cnt", longint'(doneCnt[0]), 0);
        chk("rst_doneB_cnt", longint'(doneCnt[1]), 0);
        chk("rst_corrA", longint'(corrV[0]), 0);
        chk("rst_busyA", longint'(busyV[0]), 0);
        clearLogs();
        doStart(5, 5, n0);
        repeat (30) @(negedge iCLK);
        chk("post_rst_corrA", longint'(corrV[0]), 4);
        chk("post_rst_doneA_cnt", longint'(doneCnt[0]), 1);

        // Full-scale pixels; the 16-bit instance overflows.
        dmode = 1;
        chk("model_max4", score(1, 0, 0), 1040400);
        clearLogs();
        doStart(0, 0, n0);
        repeat (30) @(negedge iCLK);
        chk("max_corrA", longint'(corrV[0]), 260100);
        chk("max_corrB", longint'(corrV[1]), 1040400);
        chk("max_doneB_ofs", longint'(doneEdge[1] - n0), 20);
`ifdef CORR_SAT_EN
        chk("max_corrC_sat", longint'(corrV[2]), 65535);
`else
        chk("max_corrC_wrap", longint'(corrV[2]), 57360);
`endif
        chk("max_readsB", longint'(readCnt[1]), 16);
        chk("max_addrB0", longint'(rdLog[1][0]), 0);
        chk("max_addrB1", longint'(rdLog[1][1]), 1);
        chk("max_addrB2", longint'(rdLog[1][2]), 2);
        chk("max_addrB3", longint'(rdLog[1][3]), 3);
        chk("max_addrB4", longint'(rdLog[1][4]), 640);
        chk("max_addrB5", longint'(rdLog[1][5]), 641);

        // Bottom-right corner: a single pixel survives clipping.
        dmode = 0;
        clearLogs();
        doStart(639, 479, n0);
        repeat (30) @(negedge iCLK);
        chk("clip_corrA", longint'(corrV[0]), 1);
        chk("clip_readsA", longint'(readCnt[0]), 1);
        chk("clip_corrB", longint'(corrV[1]), 1);
        chk("clip_readsB", longint'(readCnt[1]), 1);

        // Start held high while X slides left one pixel per cycle.
        clearLogs();
        @(negedge iCLK);
        n0 = cyc;
        for (int m = 0; m <= 22; m++) begin
            iStart = 1'b1;
            iX     = 13'(639 - m);
            iY     = 13'd0;
            @(negedge iCLK);
        end
        iStart = 1'b0;
        repeat (30) @(negedge iCLK);
        chk("b2b_accA0", longint'(accE[0][0] - n0), 0);
        chk("b2b_accA1", longint'(accE[0][1] - n0), 10);
        chk("b2b_accA_cnt", longint'(accCnt[0]), 3);
        chk("b2b_corrA0", doneCorr[0][0], 2);
        chk("b2b_corrA1", doneCorr[0][1], 4);
        chk("b2b_accB1", longint'(accE[1][1] - n0), 22);
        chk("b2b_accB_cnt", longint'(accCnt[1]), 2);
        chk("b2b_corrB0", doneCorr[1][0], 4);
        chk("b2b_corrB1", doneCorr[1][1], 16);

        // Position-dependent data exercises ordering of frame and template addresses.
        dmode = 2;
        clearLogs();
        doStart(100, 50, n0);
        repeat (30) @(negedge iCLK);
        clearLogs();
        doStart(637, 478, n0);
        repeat (30) @(negedge iCLK);
        chk("pat_readsA", longint'(readCnt[0]), 4);
        chk("pat_readsB", longint'(readCnt[1]), 6);
        doStart(0, 479, n0);
        repeat (30) @(negedge iCLK);
        doStart(630, 200, n0);
        repeat (30) @(negedge iCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/corr_window_engine.md
# corr_window_engine

Computes the template correlation score for one candidate (X, Y) position of the stored frame and hands it to the coordinate-search controller. The engine sits directly upstream of that controller. The controller supplies start coordinates. The engine reads a TW×TH window from the frame buffer and the template ROM, and returns a sum-of-products score with a one-cycle done pulse; that pulse is the controller's correlation-finished input. There is one engine per search path, and it is reused for every candidate position.

## Interface
- H_RES, 640, frame width in pixels
- V_RES, 480, frame height in pixels
- TW, 32, template width in pixels
- TH, 32, template height in pixels
- PIX_W, 8, pixel width (unsigned)
- ADDR_W, 19, frame-buffer address width
- ACC_W, 32, accumulator width (≤ 32)
- iCLK  in  1  system clock (50 MHz); single clock domain
- iRST  in  1  reset, synchronous, active-high
- iStart  in  1  start request; sampled only in IDLE
- iX  in  13  window origin X, latched on accepted start
- iY  in  13  window origin Y, latched on accepted start
- oFrameRd  out  1  frame-buffer read strobe
- oFrameAddr  out  ADDR_W  frame address = (Y+j)*H_RES + (X+i)
- iFramePix  in  PIX_W  frame data; valid exactly 1 cycle after oFrameRd
- oTmplAddr  out  log2(TW*TH)  template address = j*TW + i
- iTmplPix  in  PIX_W  template data; valid exactly 1 cycle after address
- oBusy  out  1  high from accepted start until the cycle oDone is asserted, inclusive
- oDone  out  1  one-cycle pulse; oCorr valid
- oCorr  out  32  score, zero-extended from ACC_W; held until the next oDone

## Operation
- States:
  - IDLE: waits for a start request.
  - SETUP: one cycle; latches rowbase = iY*H_RES + iX and clears the accumulator.
  - RUN: TW*TH cycles; i runs fastest, 0..TW-1, then j increments.
  - DRAIN: 3 cycles; flushes the pipeline.
  - DONE: one cycle; oDone=1, then returns to IDLE.
- Transitions:
  - IDLE→SETUP when iStart=1.
  - SETUP→RUN unconditionally.
  - RUN→DRAIN after index (TW-1, TH-1) is issued.
  - DRAIN→DONE after 3 cycles.
  - DONE→IDLE.
- Pipeline for each window pixel:
  - Issue cycle: addresses driven.
  - +1: pixels returned.
  - +2: product registered (2*PIX_W bits).
  - +3: product added to the accumulator.
- Frame address is generated incrementally:
  - +1 per i step.
  - +(H_RES − TW + 1) at row wrap.
  - No multiply after SETUP.
- Out-of-frame pixels (X+i ≥ H_RES or Y+j ≥ V_RES):
  - oFrameRd=0 for that slot.
  - The product is forced to 0.
  - The template address still advances.
- iStart while oBusy=1 is ignored; there is no queueing.
- iX/iY changes after the accepted start have no effect on the running window.
- Reset (synchronous, any state):
  - State→IDLE.
  - Accumulator, oCorr, oDone, oBusy, oFrameRd, oFrameAddr and oTmplAddr all →0.
  - A run interrupted by reset produces no oDone.

## Timing
- iStart sampled high at edge N:
  - SETUP occupies cycle N+1.
  - RUN occupies N+2 .. N+TW*TH+1.
  - oDone is high in cycle N+TW*TH+5 only.
- Start-to-done latency is L = TW*TH + 5 cycles. With the defaults, L = 1029.
- oCorr updates on the same edge that raises oDone and is stable thereafter.
- A new iStart is accepted at earliest the cycle after DONE, i.e. cycle N+TW*TH+6.
- No backpressure: the memories must return data with fixed 1-cycle latency.

## Configuration
- CORR_SAT_EN defined:
  - The accumulator saturates at 2^ACC_W − 1.
  - Once saturated, it holds that value for the rest of the run.
- CORR_SAT_EN undefined:
  - The accumulator wraps modulo 2^ACC_W.
- No other behaviour differs, including latency.

## Test plan
- Reset check: assert iRST for 3 cycles mid-RUN (TW=TH=2) → oBusy=0, oDone never pulses, oCorr=0, next start runs normally.
- Flat frame, TW=TH=2, all frame/template pixels=1, start at X=Y=0 (edge N) → oDone only in cycle N+9, oCorr=4.
- Max pixels, TW=TH=4, all pixels=255 → oCorr=1040400, oDone at N+21; oFrameAddr sequence 0,1,2,3,640,641,…
- Edge clipping, TW=TH=2, all pixels=1, X=639, Y=479 → only one in-frame pixel; oCorr=1, oFrameRd pulses exactly once.
- Back-to-back: iStart held high continuously, with X changing every cycle → starts accepted only at N and N+TW*TH+6; each score uses the X latched at its own accept.
- Overflow, ACC_W=16, TW=TH=4, pixels=255:
  - With CORR_SAT_EN → oCorr=65535.
  - Without CORR_SAT_EN → oCorr=57360.
